rtc_event_scheduler: RTL and testbench

RTC_EVENT_SCHEDULER -- requirements
Module: rtc_event_scheduler

---
 rtl/rtc_event_scheduler.sv | 158 +++++++++++++++
 tb/tb_rtc_event_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_event_scheduler.sv
// RTC-timed event scheduler: a FIFO of {sec, nsec, tag} events, each fired when the RTC reaches its target.
// Build option RTC_SCHED_LATE_DROP_EN: a head that is already due when loaded is dropped (drop_out) instead of fired.
module rtc_event_scheduler #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [31:0]            rtc_sec,
    input  logic [31:0]            rtc_nsec,
    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [31:0]            sched_sec,
    input  logic [31:0]            sched_nsec,
    input  logic [TAG_WIDTH-1:0]   sched_tag,
    input  logic                   flush,
    output logic                   trig_out,
    output logic [TAG_WIDTH-1:0]   trig_tag,
    output logic                   trig_late,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        FIRE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [63:0]          mem_time [DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag  [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_next;
    logic [63:0]          head_time;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [63:0]          cmp_time;
    logic                 due_now;
    logic                 due_q;
    logic                 late_q;
    logic                 push;
    logic                 pop;

    assign sched_ready = !areset && !flush && (level_q < FULL_LEVEL);
    assign push        = sched_valid && sched_ready;
    assign pop         = (state == FIRE) && !flush;
    assign level       = level_q;

    // During LOAD the head register is still being filled, so compare straight against the FIFO slot.
    assign cmp_time = (state == LOAD) ? mem_time[rd_ptr] : head_time;
    assign due_now  = {rtc_sec, rtc_nsec} >= cmp_time;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        level_next = level_q;

        case ({push, pop})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase

        case (state)
            IDLE:    if (level_q != '0) state_next = LOAD;
            LOAD:    state_next = WAIT;
            WAIT:    if (due_q) state_next = FIRE;
            FIRE:    state_next = (level_next != '0) ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase

        if (flush) state_next = IDLE;
    end

    // NOTE: the event storage has no reset; a slot is only ever read behind a nonzero level.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_time[wr_ptr] <= {sched_sec, sched_nsec};
            mem_tag[wr_ptr]  <= sched_tag;
        end
    end

`ifdef RTC_SCHED_LATE_DROP_EN
    logic drop_q;
    assign drop_out = drop_q;
`else
    assign drop_out = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            due_q     <= 1'b0;
            late_q    <= 1'b0;
            head_time <= '0;
            head_tag  <= '0;
            trig_out  <= 1'b0;
            trig_tag  <= '0;
            trig_late <= 1'b0;
`ifdef RTC_SCHED_LATE_DROP_EN
            drop_q    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            trig_out  <= 1'b0;
            trig_late <= 1'b0;
            due_q     <= due_now;
`ifdef RTC_SCHED_LATE_DROP_EN
            drop_q    <= 1'b0;
`endif
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
                due_q   <= 1'b0;
                late_q  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level_q <= level_next;

                if (state == LOAD) begin
                    head_time <= mem_time[rd_ptr];
                    head_tag  <= mem_tag[rd_ptr];
                    late_q    <= due_now;
                end

                if (pop) begin
`ifdef RTC_SCHED_LATE_DROP_EN
                    if (late_q) begin
                        drop_q <= 1'b1;
                    end else begin
                        trig_out <= 1'b1;
                        trig_tag <= head_tag;
                    end
`else
                    trig_out  <= 1'b1;
                    trig_tag  <= head_tag;
                    trig_late <= late_q;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_event_scheduler.sv
// Self-checking bench for rtc_event_scheduler: directed scenarios plus random traffic against a timing model.
// Expectations follow RTC_SCHED_LATE_DROP_EN when it is defined for the build.
module tb_rtc_event_scheduler;

    localparam int     DEPTH     = 4;
    localparam int     TAG_WIDTH = 8;
    localparam int     LVL_W     = $clog2(DEPTH) + 1;
    localparam longint NS        = 64'd1_000_000_000;
`ifdef RTC_SCHED_LATE_DROP_EN
    localparam bit     DROP      = 1'b1;
`else
    localparam bit     DROP      = 1'b0;
`endif

    typedef struct {
        longint               t;
        logic [TAG_WIDTH-1:0] tag;
    } ev_t;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic [31:0]          rtc_sec;
    logic [31:0]          rtc_nsec;
    logic                 sched_valid;
    logic                 sched_ready;
    logic [31:0]          sched_sec;
    logic [31:0]          sched_nsec;
    logic [TAG_WIDTH-1:0] sched_tag;
    logic                 flush;
    logic                 trig_out;
    logic [TAG_WIDTH-1:0] trig_tag;
    logic                 trig_late;
    logic [LVL_W-1:0]     level;
    logic                 drop_out;

    rtc_event_scheduler #(
        .DEPTH    (DEPTH),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .rtc_sec    (rtc_sec),
        .rtc_nsec   (rtc_nsec),
        .sched_valid(sched_valid),
        .sched_ready(sched_ready),
        .sched_sec  (sched_sec),
        .sched_nsec (sched_nsec),
        .sched_tag  (sched_tag),
        .flush      (flush),
        .trig_out   (trig_out),
        .trig_tag   (trig_tag),
        .trig_late  (trig_late),
        .level      (level),
        .drop_out   (drop_out)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of pending events plus the cycle at which the head becomes eligible and fires.
    ev_t                  q[$];
    longint               cyc      = 0;
    longint               load_at  = -1;
    longint               fire_at  = -1;
    bit                   fire_late;
    bit                   exp_trig;
    bit                   exp_drop;
    bit                   exp_late;
    logic [TAG_WIDTH-1:0] exp_tag  = '0;

    longint               rtc_ns   = 0;
    longint               step_ns  = 0;
    int                   n_trig;
    int                   n_drop;
    logic [TAG_WIDTH-1:0] seen_tags[$];
    longint               seen_cyc[$];
    bit                   last_late;
    logic [TAG_WIDTH-1:0] last_tag;
    longint               trig_rtc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_rtc(input longint t);
        rtc_ns   = t;
        rtc_sec  = 32'(t / NS);
        rtc_nsec = 32'(t % NS);
    endtask

    task automatic drive_sched(input longint t, input logic [TAG_WIDTH-1:0] tag);
        sched_sec  = 32'(t / NS);
        sched_nsec = 32'(t % NS);
        sched_tag  = tag;
    endtask

    task automatic clear_obs();
        n_trig = 0;
        n_drop = 0;
        seen_tags.delete();
        seen_cyc.delete();
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare every output.
    task automatic cycle();
        bit     push_ok;
        bit     fired;
        bit     exp_rdy;
        int     pre;
        longint edge_rtc;
        ev_t    ev;
        @(posedge aclk);
        edge_rtc = rtc_ns;
        pre      = q.size();
        push_ok  = sched_valid && !areset && !flush && (pre < DEPTH);
        exp_trig = 1'b0;
        exp_drop = 1'b0;
        exp_late = 1'b0;
        fired    = 1'b0;
        if (areset || flush) begin
            q.delete();
            load_at = -1;
            fire_at = -1;
            if (areset) exp_tag = '0;
        end else begin
            if (fire_at == cyc) begin
                ev    = q.pop_front();
                fired = 1'b1;
                if (DROP && fire_late) begin
                    exp_drop = 1'b1;
                end else begin
                    exp_trig = 1'b1;
                    exp_tag  = ev.tag;
                    exp_late = fire_late;
                end
            end
            if (push_ok) begin
                ev.t   = longint'({32'd0, sched_sec}) * NS + longint'({32'd0, sched_nsec});
                ev.tag = sched_tag;
                q.push_back(ev);
            end
            if (fired) begin
                fire_at = -1;
                load_at = (q.size() > 0) ? cyc + 1 : -1;
            end else if (load_at < 0) begin
                if (pre > 0) load_at = cyc + 1;
            end else if (fire_at < 0 && cyc >= load_at && edge_rtc >= q[0].t) begin
                fire_at   = cyc + 2;
                fire_late = (cyc == load_at);
            end
        end
        cyc++;
        #1;
        exp_rdy = !areset && !flush && (q.size() < DEPTH);
        check("trig_out", 64'(trig_out), 64'(exp_trig));
        check("drop_out", 64'(drop_out), 64'(exp_drop));
        check("trig_late", 64'(trig_late), 64'(exp_late));
        check("level", 64'(level), 64'(q.size()));
        check("sched_ready", 64'(sched_ready), 64'(exp_rdy));
        if (exp_trig) check("trig_tag", 64'(trig_tag), 64'(exp_tag));
        if (trig_out) begin
            n_trig++;
            seen_tags.push_back(trig_tag);
            seen_cyc.push_back(cyc);
            last_late = trig_late;
            last_tag  = trig_tag;
            trig_rtc  = edge_rtc;
        end
        if (drop_out) n_drop++;
        set_rtc(rtc_ns + step_ns);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until(input int max, input string name);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!trig_out && !drop_out && k < max);
        check({name, "_seen"}, 64'(trig_out | drop_out), 64'd1);
    endtask

    task automatic push_one(input longint t, input logic [TAG_WIDTH-1:0] tag);
        drive_sched(t, tag);
        sched_valid = 1'b1;
        cycle();
        sched_valid = 1'b0;
    endtask

    initial begin
        longint t;
        longint last_t;

        areset      = 1'b1;
        flush       = 1'b0;
        sched_valid = 1'b0;
        drive_sched(0, '0);
        set_rtc(0);
        clear_obs();

        // Reset state
        run(3);
        check("rst_level", 64'(level), 64'd0);
        check("rst_trig", 64'(trig_out), 64'd0);
        check("rst_tag", 64'(trig_tag), 64'd0);
        check("rst_late", 64'(trig_late), 64'd0);
        check("rst_drop", 64'(drop_out), 64'd0);
        check("rst_ready", 64'(sched_ready), 64'd0);
        areset = 1'b0;
        cycle();
        check("ready_after_rst", 64'(sched_ready), 64'd1);

        // Event at 11 s 0 ns with the RTC ticking 1 ns per cycle across the second boundary
        set_rtc(10 * NS + 999_999_990);
        step_ns = 1;
        clear_obs();
        push_one(11 * NS, 8'h5A);
        run_until(40, "s33");
        check("s33_tag", 64'(last_tag), 64'h5A);
        check("s33_late", 64'(last_late), 64'd0);
        check("s33_rtc_at_fire", 64'(trig_rtc), 64'(11 * NS + 2));
        run(5);

        // Fill to DEPTH, refuse a fifth, then free one slot by firing
        step_ns = 0;
        set_rtc(100 * NS);
        clear_obs();
        sched_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_sched(101 * NS, 8'(8'h10 + i));
            cycle();
        end
        check("s34_full_level", 64'(level), 64'(DEPTH));
        check("s34_full_ready", 64'(sched_ready), 64'd0);
        drive_sched(101 * NS, 8'h14);
        cycle();
        sched_valid = 1'b0;
        check("s34_fifth_level", 64'(level), 64'(DEPTH));
        set_rtc(101 * NS);
        run_until(20, "s34");
        check("s34_level", 64'(level), 64'(DEPTH - 1));
        check("s34_ready", 64'(sched_ready), 64'd1);
        check("s34_tag", 64'(last_tag), 64'h10);
        run(20);
        check("s34_total", 64'(n_trig), 64'(DEPTH));

        // Late event: RTC already at 20 s, target 5 s
        set_rtc(20 * NS);
        clear_obs();
        push_one(5 * NS, 8'h01);
        run_until(20, "s35");
`ifdef RTC_SCHED_LATE_DROP_EN
        check("s35_drop", 64'(n_drop), 64'd1);
        check("s35_trig", 64'(n_trig), 64'd0);
`else
        check("s35_trig", 64'(n_trig), 64'd1);
        check("s35_late", 64'(last_late), 64'd1);
        check("s35_tag", 64'(last_tag), 64'h01);
`endif
        run(5);

        // Three events due together fire 3 cycles apart in FIFO order
        set_rtc(6 * NS);
        sched_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_sched(7 * NS, 8'(i));
            cycle();
        end
        sched_valid = 1'b0;
        run(4);
        clear_obs();
        set_rtc(8 * NS);
        run(20);
        check("s36_count", 64'(n_trig), 64'd3);
        if (n_trig == 3) begin
            check("s36_tag0", 64'(seen_tags[0]), 64'd1);
            check("s36_tag1", 64'(seen_tags[1]), 64'd2);
            check("s36_tag2", 64'(seen_tags[2]), 64'd3);
            check("s36_gap1", 64'(seen_cyc[1] - seen_cyc[0]), 64'd3);
            check("s36_gap2", 64'(seen_cyc[2] - seen_cyc[1]), 64'd3);
        end

        // Flush together with a push discards everything
        set_rtc(30 * NS);
        push_one(40 * NS, 8'h21);
        push_one(40 * NS, 8'h22);
        run(3);
        drive_sched(40 * NS, 8'h77);
        sched_valid = 1'b1;
        flush       = 1'b1;
        cycle();
        sched_valid = 1'b0;
        flush       = 1'b0;
        check("s37_level", 64'(level), 64'd0);
        clear_obs();
        set_rtc(50 * NS);
        run(20);
        check("s37_notrig", 64'(n_trig), 64'd0);

        // Reset while waiting on queued events
        set_rtc(60 * NS);
        sched_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_sched(70 * NS, 8'(8'h30 + i));
            cycle();
        end
        sched_valid = 1'b0;
        run(5);
        areset = 1'b1;
        cycle();
        check("s38_level", 64'(level), 64'd0);
        areset = 1'b0;
        clear_obs();
        set_rtc(80 * NS);
        run(20);
        check("s38_notrig", 64'(n_trig), 64'd0);

        // Random traffic across a second boundary, with occasional flush and reset
        set_rtc(200 * NS + NS - 500);
        last_t = 0;
        for (int i = 0; i < 3000; i++) begin
            step_ns     = longint'($urandom_range(0, 4));
            flush       = ($urandom_range(0, 149) == 0);
            areset      = ($urandom_range(0, 399) == 0);
            sched_valid = ($urandom_range(0, 2) == 0);
            t = rtc_ns + longint'($urandom_range(0, 200)) - 40;
            if (t < last_t) t = last_t;
            last_t = t;
            drive_sched(t, 8'($urandom));
            cycle();
        end
        flush       = 1'b0;
        areset      = 1'b0;
        sched_valid = 1'b0;
        step_ns     = 50;
        run(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
